// File: rtl/multi_stage_pkg.sv
// Shared types and helpers for the multi-stage priority decoder.
// Index width, NULL detection and the decoder state encoding.
package multi_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } dec_state_t;

    function automatic int idx_width(input int inputs);
        return $clog2(inputs);
    endfunction

    // Any index at or above the vector width is a NULL stage.
    function automatic logic idx_is_null(
        input int unsigned idx,
        input int unsigned inputs
    );
        return idx >= inputs;
    endfunction

endpackage

// File: rtl/index_onehot_decoder.sv
// Combinational index-to-onehot decoder.
// NULL indices produce an all-zero vector and raise is_null.
module index_onehot_decoder
    import multi_stage_pkg::*;
#(
    parameter int INPUTS = 12,
    localparam int W = idx_width(INPUTS)
) (
    input  logic [W-1:0]      idx,
    output logic [INPUTS-1:0] onehot,
    output logic              is_null
);

    localparam logic [INPUTS-1:0] ONE = {{(INPUTS-1){1'b0}}, 1'b1};

    always_comb begin
        is_null = idx_is_null(32'(idx), INPUTS);
        onehot  = '0;
        if (!is_null) begin
            onehot = ONE << idx;
        end
    end

endmodule

// File: rtl/multi_stage_priority_decoder.sv
// Rebuilds a request vector from a packed list of stage indices,
// folding one stage per clock and flagging repeated indices.
module multi_stage_priority_decoder
    import multi_stage_pkg::*;
#(
    parameter int INPUTS = 12,
    parameter int STAGES = 7,
    localparam int W   = idx_width(INPUTS),
    localparam int CW  = $clog2(STAGES + 1),
    localparam int SCW = $clog2(STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W*STAGES-1:0] in_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INPUTS-1:0]   out_vec,
    output logic [CW-1:0]       out_count,
    output logic                out_dup
);

    dec_state_t          state;
    logic [W*STAGES-1:0] shreg;
    logic [INPUTS-1:0]   acc;
    logic [CW-1:0]       count;
    logic                dup;
    logic [SCW-1:0]      stage_cnt;

    logic [INPUTS-1:0]   onehot;
    logic                is_null;
    logic                hit;
    logic                last;

    index_onehot_decoder #(
        .INPUTS (INPUTS)
    ) u_dec (
        .idx     (shreg[W-1:0]),
        .onehot  (onehot),
        .is_null (is_null)
    );

    assign hit  = |(acc & onehot);
    assign last = (stage_cnt == SCW'(STAGES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            shreg     <= '0;
            acc       <= '0;
            count     <= '0;
            dup       <= 1'b0;
            stage_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg     <= in_idx;
                        acc       <= '0;
                        count     <= '0;
                        dup       <= 1'b0;
                        stage_cnt <= '0;
                        in_ready  <= 1'b0;
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    if (!is_null) begin
                        if (hit) begin
                            dup <= 1'b1;
                        end else begin
                            acc   <= acc | onehot;
                            count <= count + CW'(1);
                        end
                    end
                    shreg     <= shreg >> W;
                    stage_cnt <= stage_cnt + SCW'(1);
                    if (last) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign out_vec   = acc;
    assign out_count = count;
    assign out_dup   = dup;

endmodule

// File: tb/tb_multi_stage_priority_decoder.sv
// Self-checking bench for multi_stage_priority_decoder.
// Directed words, backpressure, reset abort and random round trips.
module tb_multi_stage_priority_decoder;

    localparam int INPUTS = 12;
    localparam int STAGES = 7;
    localparam int W      = $clog2(INPUTS);
    localparam int CW     = $clog2(STAGES + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [W*STAGES-1:0] in_idx;
    logic                out_valid;
    logic                out_ready;
    logic [INPUTS-1:0]   out_vec;
    logic [CW-1:0]       out_count;
    logic                out_dup;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_stage_priority_decoder #(
        .INPUTS (INPUTS),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    function automatic logic [W*STAGES-1:0] pack(input int s[STAGES]);
        logic [W*STAGES-1:0] w;
        w = '0;
        for (int k = 0; k < STAGES; k++) begin
            w[k*W +: W] = W'(s[k]);
        end
        return w;
    endfunction

    // Set semantics: the vector is the set of non-null indices;
    // a duplicate exists when non-null stages outnumber set bits.
    function automatic void model(
        input  int                s[STAGES],
        output logic [INPUTS-1:0] v,
        output int                cnt,
        output logic              d
    );
        int nn;
        nn = 0;
        v  = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (s[k] < INPUTS) begin
                v[s[k]] = 1'b1;
                nn++;
            end
        end
        cnt = $countones(v);
        d   = (nn > cnt);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [W*STAGES-1:0] word,
                            output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_idx   = word;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_idx    = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
                out_vec !== '0 || out_count !== '0 || out_dup !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d rdy=%b vld=%b vec=%h cnt=%0d dup=%b exp rdy=1 vld=0 vec=0 cnt=0 dup=0",
                         c, in_ready, out_valid, out_vec, out_count, out_dup);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int s[STAGES];
        logic seen;
        s = '{0, 1, 2, 3, 4, 5, 6};
        in_valid = 1'b1;
        in_idx   = pack(s);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst  = 1'b1;
        seen = out_valid;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_vec !== '0 || out_count !== '0) begin
            failures++;
            $display("FAIL reset_mid rdy=%b vec=%h cnt=%0d exp rdy=1 vec=0 cnt=0",
                     in_ready, out_vec, out_count);
        end
        for (int c = 0; c < 12; c++) begin
            seen = seen | out_valid;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_novalid out_valid_seen=%b exp=0", seen);
        end
    endtask

    task automatic test_directed();
        int                s[4][STAGES];
        logic [INPUTS-1:0] ev[4];
        int                ec[4];
        logic              ed[4];
        int                lat;
        s[0] = '{1, 3, 5, 15, 15, 15, 15};
        s[1] = '{0, 1, 2, 3, 4, 5, 11};
        s[2] = '{4, 4, 9, 12, 13, 14, 15};
        s[3] = '{12, 12, 12, 12, 12, 12, 12};
        ev   = '{12'h02A, 12'h83F, 12'h210, 12'h000};
        ec   = '{3, 7, 2, 0};
        ed   = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_word(pack(s[i]), lat);
            checks++;
            if (lat !== STAGES || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_latency lat=%0d vld=%b rdy=%b exp lat=%0d vld=1 rdy=0",
                         i, lat, out_valid, in_ready, STAGES);
            end
            checks++;
            if (out_vec !== ev[i] || out_count !== CW'(ec[i]) ||
                out_dup !== ed[i]) begin
                failures++;
                $display("FAIL dir%0d_result vec=%h cnt=%0d dup=%b exp vec=%h cnt=%0d dup=%b",
                         i, out_vec, out_count, out_dup, ev[i], ec[i], ed[i]);
            end
            release_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_release vld=%b rdy=%b exp vld=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int                s1[STAGES];
        int                s2[STAGES];
        logic [INPUTS-1:0] v;
        int                c2;
        logic              d2;
        int                lat;
        s1 = '{7, 2, 2, 13, 0, 15, 14};
        s2 = '{10, 11, 6, 12, 8, 9, 1};
        run_word(pack(s1), lat);
        in_valid = 1'b1;
        in_idx   = pack(s2);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_vec !== 12'h085 || out_count !== CW'(3) ||
                out_dup !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d vld=%b rdy=%b vec=%h cnt=%0d dup=%b exp vld=1 rdy=0 vec=085 cnt=3 dup=1",
                         c, out_valid, in_ready, out_vec, out_count, out_dup);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release vld=%b rdy=%b exp vld=0 rdy=1",
                     out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        model(s2, v, c2, d2);
        checks++;
        if (lat !== STAGES || out_vec !== v || out_count !== CW'(c2) ||
            out_dup !== d2) begin
            failures++;
            $display("FAIL bp_second lat=%0d vec=%h cnt=%0d dup=%b exp lat=%0d vec=%h cnt=%0d dup=%b",
                     lat, out_vec, out_count, out_dup, STAGES, v, c2, d2);
        end
        release_out();
    endtask

    task automatic test_round_trip();
        logic [INPUTS-1:0] vec;
        int                s[STAGES];
        int                n;
        int                k;
        int                lat;
        for (int it = 0; it < 40; it++) begin
            vec = '0;
            n   = $urandom_range(0, STAGES);
            for (int j = 0; j < n; j++) begin
                vec[$urandom_range(0, INPUTS - 1)] = 1'b1;
            end
            k = 0;
            for (int b = 0; b < INPUTS; b++) begin
                if (vec[b]) begin
                    s[k] = b;
                    k++;
                end
            end
            for (int j = k; j < STAGES; j++) begin
                s[j] = $urandom_range(INPUTS, (1 << W) - 1);
            end
            run_word(pack(s), lat);
            checks++;
            if (lat !== STAGES || out_vec !== vec ||
                out_count !== CW'($countones(vec)) || out_dup !== 1'b0) begin
                failures++;
                $display("FAIL round_trip it=%0d lat=%0d vec=%h cnt=%0d dup=%b exp vec=%h cnt=%0d dup=0",
                         it, lat, out_vec, out_count, out_dup, vec, $countones(vec));
            end
            release_out();
        end
    endtask

    task automatic test_random_words();
        int                s[STAGES];
        logic [INPUTS-1:0] v;
        int                c;
        logic              d;
        int                lat;
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < STAGES; j++) begin
                s[j] = $urandom_range(0, (1 << W) - 1);
            end
            model(s, v, c, d);
            run_word(pack(s), lat);
            checks++;
            if (lat !== STAGES || out_vec !== v || out_count !== CW'(c) ||
                out_dup !== d) begin
                failures++;
                $display("FAIL random_word it=%0d lat=%0d vec=%h cnt=%0d dup=%b exp vec=%h cnt=%0d dup=%b",
                         it, lat, out_vec, out_count, out_dup, v, c, d);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        test_random_words();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
